// File: rtl/nec_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch queue and nec_decode.
package nec_prefetch_pkg;

    localparam int unsigned IPQ_DEPTH = 8;
    localparam int unsigned IPQ_PTR_W = 3;
    localparam int unsigned IPQ_LEN_W = 4;
    localparam int unsigned LEN_SUM_W = IPQ_LEN_W + 1;
    localparam int unsigned PHYS_W    = 20;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_REQ,
        PF_DISCARD
    } prefetch_state_e;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
    } fetch_word_t;

    typedef logic [IPQ_DEPTH-1:0][7:0] ipq_t;

    // Word-aligned segment:offset translation with 20-bit wrap.
    function automatic logic [PHYS_W-1:0] phys_word_addr(input logic [15:0] seg,
                                                         input logic [15:0] ip);
        return PHYS_W'({seg, 4'h0}) + PHYS_W'({ip[15:1], 1'b0});
    endfunction

endpackage

// File: rtl/nec_prefetch_if.sv
// Code-fetch bus between the prefetch queue (master) and the bus unit (slave).
interface nec_prefetch_if;
    import nec_prefetch_pkg::*;

    logic               fetch_req;
    logic [PHYS_W-1:0]  fetch_addr;
    logic               fetch_ack;
    fetch_word_t        fetch_data;

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_ack,
        input  fetch_data
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_ack,
        output fetch_data
    );

endinterface

// File: rtl/nec_prefetch.sv
// nec_prefetch: 8-byte instruction prefetch ring indexed by IP[2:0], feeding nec_decode.
// Defining NEC_PREFETCH_PERF_EN adds fetch/flush/starvation counters.
module nec_prefetch
    import nec_prefetch_pkg::*;
#(
    parameter int unsigned FETCH_THRESHOLD = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic [15:0]          ps,
    input  logic                 set_pc,
    input  logic [15:0]          new_pc,
    input  logic                 consume,
    input  logic [IPQ_LEN_W-1:0] consume_len,
    nec_prefetch_if.master       bus,
    output ipq_t                 ipq,
    output logic [IPQ_LEN_W-1:0] ipq_len,
    output logic [15:0]          head_pc
`ifdef NEC_PREFETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetches,
    output logic [31:0]          perf_flushes,
    output logic [31:0]          perf_starve
`endif
);

    prefetch_state_e       state_q, state_d;
    logic                  fetch_req_q, fetch_req_d;
    logic [PHYS_W-1:0]     fetch_addr_q, fetch_addr_d;
    logic [15:0]           head_pc_q, head_pc_d;
    logic [IPQ_LEN_W-1:0]  ipq_len_q, ipq_len_d;
    ipq_t                  ipq_q, ipq_d;

    logic [15:0]           fetch_ip_c;
    logic [15:0]           issue_ip_c;
    logic [IPQ_LEN_W-1:0]  free_c;
    logic [IPQ_PTR_W-1:0]  wr_ptr_c;
    logic [LEN_SUM_W-1:0]  len_sum_c;
    logic [LEN_SUM_W-1:0]  consumed_c;
    logic [1:0]            added_c;
    logic                  issue_c;

    // Next byte to fetch is always the one just past the valid window.
    assign fetch_ip_c = head_pc_q + 16'(ipq_len_q);
    assign free_c     = IPQ_LEN_W'(IPQ_DEPTH) - ipq_len_q;
    assign wr_ptr_c   = fetch_ip_c[IPQ_PTR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PF_IDLE;
            fetch_req_q  <= 1'b0;
            fetch_addr_q <= '0;
            head_pc_q    <= '0;
            ipq_len_q    <= '0;
            ipq_q        <= '0;
        end else begin
            state_q      <= state_d;
            fetch_req_q  <= fetch_req_d;
            fetch_addr_q <= fetch_addr_d;
            head_pc_q    <= head_pc_d;
            ipq_len_q    <= ipq_len_d;
            ipq_q        <= ipq_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_req_d  = fetch_req_q;
        fetch_addr_d = fetch_addr_q;
        head_pc_d    = head_pc_q;
        ipq_len_d    = ipq_len_q;
        ipq_d        = ipq_q;
        added_c      = '0;
        issue_c      = 1'b0;
        len_sum_c    = '0;
        consumed_c   = '0;
        issue_ip_c   = '0;

        if (ce) begin
            unique case (state_q)
                PF_IDLE: begin
                    if (!set_pc && (free_c >= IPQ_LEN_W'(FETCH_THRESHOLD))) begin
                        issue_c     = 1'b1;
                        state_d     = PF_REQ;
                        fetch_req_d = 1'b1;
                    end
                end
                PF_REQ: begin
                    if (bus.fetch_ack) begin
                        state_d     = PF_IDLE;
                        fetch_req_d = 1'b0;
                        // A same-cycle flush wins over the returning data.
                        if (!set_pc) begin
                            if (fetch_ip_c[0]) begin
                                ipq_d[wr_ptr_c] = bus.fetch_data.hi;
                                added_c         = 2'd1;
                            end else begin
                                ipq_d[wr_ptr_c]         = bus.fetch_data.lo;
                                ipq_d[wr_ptr_c + 3'd1]  = bus.fetch_data.hi;
                                added_c                 = 2'd2;
                            end
                        end
                    end else if (set_pc) begin
                        state_d = PF_DISCARD;
                    end
                end
                PF_DISCARD: begin
                    if (bus.fetch_ack) begin
                        state_d     = PF_IDLE;
                        fetch_req_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = PF_IDLE;
                    fetch_req_d = 1'b0;
                end
            endcase

            len_sum_c = LEN_SUM_W'(ipq_len_q) + LEN_SUM_W'(added_c);

            if (set_pc) begin
                head_pc_d = new_pc;
                ipq_len_d = '0;
            end else begin
                if (consume) begin
                    head_pc_d  = head_pc_q + 16'(consume_len);
                    consumed_c = LEN_SUM_W'(consume_len);
                end
                // Over-consumption empties the queue; head still advances.
                ipq_len_d = (consumed_c > len_sum_c) ? '0
                                                     : IPQ_LEN_W'(len_sum_c - consumed_c);
            end

            // Address from the post-update window so a same-cycle consume cannot skew it.
            issue_ip_c = head_pc_d + 16'(ipq_len_d);
            if (issue_c) begin
                fetch_addr_d = phys_word_addr(ps, issue_ip_c);
            end
        end
    end

    assign bus.fetch_req  = fetch_req_q;
    assign bus.fetch_addr = fetch_addr_q;
    assign ipq            = ipq_q;
    assign ipq_len        = ipq_len_q;
    assign head_pc        = head_pc_q;

`ifdef NEC_PREFETCH_PERF_EN
    logic [31:0] perf_fetches_q;
    logic [31:0] perf_flushes_q;
    logic [31:0] perf_starve_q;

    // Free-running wrap-around counters; acks while discarding still count as fetches.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetches_q <= '0;
            perf_flushes_q <= '0;
            perf_starve_q  <= '0;
        end else if (ce) begin
            if (bus.fetch_ack && (state_q != PF_IDLE)) begin
                perf_fetches_q <= perf_fetches_q + 32'd1;
            end
            if (set_pc) begin
                perf_flushes_q <= perf_flushes_q + 32'd1;
            end
            if ((ipq_len_q == '0) && (state_q != PF_IDLE)) begin
                perf_starve_q <= perf_starve_q + 32'd1;
            end
        end
    end

    assign perf_fetches = perf_fetches_q;
    assign perf_flushes = perf_flushes_q;
    assign perf_starve  = perf_starve_q;
`endif

endmodule

// File: tb/tb_nec_prefetch.sv
// Bench for nec_prefetch: directed scenarios plus random traffic against a byte-queue model.
module tb_nec_prefetch;
    import nec_prefetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [15:0] ps;
    logic        set_pc;
    logic [15:0] new_pc;
    logic        consume;
    logic [3:0]  consume_len;
    ipq_t        ipq;
    logic [3:0]  ipq_len;
    logic [15:0] head_pc;

    nec_prefetch_if bus ();

`ifdef NEC_PREFETCH_PERF_EN
    logic [31:0] perf_fetches, perf_flushes, perf_starve;
    int unsigned m_fetches, m_flushes;
`endif

    int tests = 0;
    int fails = 0;

    // Model: the valid instruction bytes in stream order, starting at m_head.
    logic [7:0]  m_q[$];
    logic [15:0] m_head;
    bit          m_stale;

    nec_prefetch #(.FETCH_THRESHOLD(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .ps          (ps),
        .set_pc      (set_pc),
        .new_pc      (new_pc),
        .consume     (consume),
        .consume_len (consume_len),
        .bus         (bus),
        .ipq         (ipq),
        .ipq_len     (ipq_len),
        .head_pc     (head_pc)
`ifdef NEC_PREFETCH_PERF_EN
        ,
        .perf_fetches(perf_fetches),
        .perf_flushes(perf_flushes),
        .perf_starve (perf_starve)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] exp_addr(input logic [15:0] seg, input logic [15:0] ip);
        int unsigned a;
        a = 32'(seg) * 32'd16 + 32'(ip & 16'hFFFE);
        return 20'(a % 32'h100000);
    endfunction

    task automatic compare_state();
        logic [63:0] exp_v;
        logic [63:0] mask;
        logic [2:0]  idx;
        exp_v = '0;
        mask  = '0;
        foreach (m_q[k]) begin
            idx = 3'(m_head + 16'(k));
            exp_v[idx*8 +: 8] = m_q[k];
            mask[idx*8 +: 8]  = 8'hFF;
        end
        check("ipq_len", 64'(ipq_len), 64'(m_q.size()));
        check("head_pc", 64'(head_pc), 64'(m_head));
        check("ipq_bytes", ipq & mask, exp_v);
        if (bus.fetch_req === 1'b1 && !m_stale)
            check("fetch_addr", 64'(bus.fetch_addr), 64'(exp_addr(ps, m_head + 16'(m_q.size()))));
`ifdef NEC_PREFETCH_PERF_EN
        check("perf_fetches", 64'(perf_fetches), 64'(m_fetches));
        check("perf_flushes", 64'(perf_flushes), 64'(m_flushes));
`endif
    endtask

    // One clock: optional ack (only if a request is visible), then model update and compare.
    task automatic cycle(input bit ack, input logic [15:0] data);
        bit          rb;
        bit          acked;
        logic [15:0] fip;
        rb    = (bus.fetch_req === 1'b1);
        acked = ack && rb && (ce === 1'b1);
        fip   = m_head + 16'(m_q.size());
        bus.fetch_ack  = acked;
        bus.fetch_data = data;
        @(posedge clk);
        #1;
        if (reset) begin
            m_q.delete();
            m_head  = '0;
            m_stale = 1'b0;
`ifdef NEC_PREFETCH_PERF_EN
            m_fetches = 0;
            m_flushes = 0;
`endif
        end else if (ce) begin
`ifdef NEC_PREFETCH_PERF_EN
            if (acked) m_fetches++;
            if (set_pc) m_flushes++;
`endif
            if (set_pc) begin
                m_q.delete();
                m_head  = new_pc;
                m_stale = rb && !acked;
            end else begin
                if (acked && !m_stale) begin
                    if (fip[0]) begin
                        m_q.push_back(data[15:8]);
                    end else begin
                        m_q.push_back(data[7:0]);
                        m_q.push_back(data[15:8]);
                    end
                end
                if (acked) m_stale = 1'b0;
                if (consume) begin
                    m_head = m_head + 16'(consume_len);
                    if (int'(consume_len) > m_q.size()) m_q.delete();
                    else repeat (int'(consume_len)) void'(m_q.pop_front());
                end
            end
        end
        set_pc        = 1'b0;
        consume       = 1'b0;
        consume_len   = '0;
        bus.fetch_ack = 1'b0;
        compare_state();
    endtask

    // Retire stale requests until a live one is on the bus (bounded).
    task automatic wait_fresh(input string tag);
        for (int i = 0; i < 16; i++) begin
            if (bus.fetch_req === 1'b1 && !m_stale) break;
            cycle(1'b1, 16'hFFFF);
        end
        check(tag, 64'(bus.fetch_req === 1'b1 && !m_stale), 64'd1);
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; ps = 16'h1000; set_pc = 1'b0; new_pc = '0;
        consume = 1'b0; consume_len = '0;
        bus.fetch_ack = 1'b0; bus.fetch_data = '0;
        m_head = '0; m_stale = 1'b0;
        cycle(1'b0, 16'h0);
        cycle(1'b0, 16'h0);
        check("rst_req", 64'(bus.fetch_req), 64'd0);
        check("rst_addr", 64'(bus.fetch_addr), 64'd0);
        check("rst_len", 64'(ipq_len), 64'd0);
        check("rst_head", 64'(head_pc), 64'd0);
        check("rst_ipq", 64'(ipq), 64'd0);
        reset = 1'b0;

        // Even branch target, full word lands in slots 0/1.
        set_pc = 1'b1; new_pc = 16'h0100; cycle(1'b0, 16'h0);
        cycle(1'b0, 16'h0);
        check("t1_req", 64'(bus.fetch_req), 64'd1);
        check("t1_addr", 64'(bus.fetch_addr), 64'h10100);
        cycle(1'b1, 16'h3412);
        check("t1_b0", 64'(ipq[0]), 64'h12);
        check("t1_b1", 64'(ipq[1]), 64'h34);
        check("t1_len", 64'(ipq_len), 64'd2);

        // Odd branch target keeps only the high byte.
        set_pc = 1'b1; new_pc = 16'h0103; cycle(1'b0, 16'h0);
        cycle(1'b0, 16'h0);
        check("t2_addr", 64'(bus.fetch_addr), 64'h10102);
        cycle(1'b1, 16'hAABB);
        check("t2_b3", 64'(ipq[3]), 64'hAA);
        check("t2_len", 64'(ipq_len), 64'd1);
        cycle(1'b0, 16'h0);
        check("t2_next", 64'(bus.fetch_addr), 64'h10104);

        // Fill to 8, then stall until the decoder frees room.
        set_pc = 1'b1; new_pc = 16'h0200; cycle(1'b0, 16'h0);
        wait_fresh("t3_fresh");
        for (int i = 0; i < 16 && ipq_len != 4'd8; i++) begin
            if (bus.fetch_req === 1'b1 && !m_stale) cycle(1'b1, 16'($urandom));
            else cycle(1'b0, 16'h0);
        end
        check("t3_full", 64'(ipq_len), 64'd8);
        repeat (3) cycle(1'b0, 16'h0);
        check("t3_stall", 64'(bus.fetch_req), 64'd0);
        consume = 1'b1; consume_len = 4'd2; cycle(1'b0, 16'h0);
        cycle(1'b0, 16'h0);
        check("t3_resume", 64'(bus.fetch_req), 64'd1);
        check("t3_addr", 64'(bus.fetch_addr), 64'h10208);

        // Flush mid-request: late ack is dropped, then refetch at the target.
        set_pc = 1'b1; new_pc = 16'h0300; cycle(1'b0, 16'h0);
        cycle(1'b0, 16'h0);
        check("t4_hold", 64'(bus.fetch_req), 64'd1);
        cycle(1'b1, 16'hFFFF);
        check("t4_len", 64'(ipq_len), 64'd0);
        check("t4_drop", 64'(bus.fetch_req), 64'd0);
        cycle(1'b0, 16'h0);
        check("t4_addr", 64'(bus.fetch_addr), 64'h10300);

        // Ack and consume in the same cycle.
        cycle(1'b1, 16'($urandom));
        wait_fresh("t5_fresh_a");
        cycle(1'b1, 16'($urandom));
        check("t5_len4", 64'(ipq_len), 64'd4);
        wait_fresh("t5_fresh_b");
        consume = 1'b1; consume_len = 4'd3; cycle(1'b1, 16'($urandom));
        check("t5_len", 64'(ipq_len), 64'd3);
        check("t5_head", 64'(head_pc), 64'h0303);

        // Physical address and head_pc wrap.
        ps = 16'hFFFF; set_pc = 1'b1; new_pc = 16'h0020; cycle(1'b0, 16'h0);
        wait_fresh("t6_fresh_a");
        check("t6_addr_wrap", 64'(bus.fetch_addr), 64'h00010);
        set_pc = 1'b1; new_pc = 16'hFFFE; cycle(1'b0, 16'h0);
        wait_fresh("t6_fresh_b");
        check("t6_addr_top", 64'(bus.fetch_addr), 64'h0FFEE);
        cycle(1'b1, 16'h5678);
        check("t6_b6", 64'(ipq[6]), 64'h78);
        check("t6_b7", 64'(ipq[7]), 64'h56);
        consume = 1'b1; consume_len = 4'd2; cycle(1'b0, 16'h0);
        check("t6_head", 64'(head_pc), 64'h0000);

        // Over-consume clamps length but still advances head.
        set_pc = 1'b1; new_pc = 16'h0400; cycle(1'b0, 16'h0);
        consume = 1'b1; consume_len = 4'd5; cycle(1'b0, 16'h0);
        check("t7_head", 64'(head_pc), 64'h0405);
        check("t7_len", 64'(ipq_len), 64'd0);

        // Clock enable low freezes everything.
        ce = 1'b0; set_pc = 1'b1; new_pc = 16'h1234; cycle(1'b0, 16'h0);
        check("t8_ce_head", 64'(head_pc), 64'h0405);
        ce = 1'b1;

        // Reset during an outstanding request.
        wait_fresh("t9_fresh");
        reset = 1'b1; cycle(1'b0, 16'h0);
        check("t9_req", 64'(bus.fetch_req), 64'd0);
        reset = 1'b0;

        ps = 16'h2000;
        for (int n = 0; n < 3000; n++) begin
            ce = (($urandom % 10) != 0);
            if (($urandom % 20) == 0) begin
                set_pc = 1'b1;
                new_pc = 16'($urandom);
                if (ce && (($urandom % 4) == 0)) ps = 16'($urandom);
            end else if (($urandom % 2) == 0) begin
                consume     = 1'b1;
                consume_len = 4'($urandom_range(0, m_q.size()));
            end
            cycle(($urandom % 3) == 0, 16'($urandom));
        end
        ce = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nec_prefetch.md
Name: nec_prefetch

Overview:
- Instruction prefetch queue (IPQ) upstream of nec_decode.
- Issues 16-bit code fetches on the bus at PS:IP, stores the returned bytes in an 8-byte ring indexed by absolute IP[2:0], and presents ipq/ipq_len to the decoder.
- Tracks decoder consumption and flushes on branch (set_pc).

Parameters:
- FETCH_THRESHOLD, 2, minimum free queue bytes (8 - ipq_len) before a new fetch is requested; legal range 2..8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable; no state changes when low
- ps  in  16  program segment, sampled when a request is issued
- set_pc  in  1  flush the queue and restart fetch at new_pc
- new_pc  in  16  branch target IP
- consume  in  1  decoder retires bytes this cycle
- consume_len  in  4  bytes retired (0..8)
- fetch_req  out  1  bus request, held until fetch_ack
- fetch_addr  out  20  word-aligned physical address = (ps<<4) + {fetch_ip[15:1],1'b0}, 20-bit wrap
- fetch_ack  in  1  one-cycle strobe; fetch_data valid in the same cycle
- fetch_data  in  16  little-endian word
- ipq  out  8x8  ring; byte for IP A sits at ipq[A[2:0]]
- ipq_len  out  4  valid bytes from head_pc (0..8)
- head_pc  out  16  IP of ipq byte 0 in sequence; mirrors decoder pc

Behaviour:
- Reset:
  - fetch_req=0, fetch_addr=0, ipq_len=0, head_pc=0, fetch_ip=0.
  - ipq contents are don't-care (cleared to 0).
  - state=IDLE.
- fetch_ip = head_pc + ipq_len (16-bit wrap). It is internal.
- States:
  - IDLE: if free >= FETCH_THRESHOLD and not set_pc, then latch fetch_addr, assert fetch_req, go to REQ. The request is visible in the next cycle.
  - REQ: hold fetch_req and fetch_addr stable until fetch_ack.
    - On ack with fetch_ip even: write data[7:0] to ipq[fetch_ip[2:0]] and data[15:8] to ipq[fetch_ip[2:0]+1]; ipq_len += 2.
    - On ack with fetch_ip odd: write data[15:8] only; ipq_len += 1.
    - After ack, go to IDLE.
  - DISCARD: entered on set_pc while in REQ without a same-cycle ack. Keep fetch_req high until fetch_ack, drop the data, then go to IDLE.
- Free-space rule: request only when free >= 2, so an even fetch never overflows. The odd case needs only 1 free byte but still obeys the threshold.
- consume: head_pc += consume_len.
  - Same-cycle ack and consume: ipq_len_next = ipq_len + added - consume_len.
  - consume_len > ipq_len (after same-cycle add) is a protocol violation. Clamp ipq_len to 0; head_pc still advances, and fetch_ip follows head_pc.
- set_pc:
  - Has priority over consume and over ack data.
  - head_pc <= new_pc, ipq_len <= 0.
  - Next state: DISCARD if a request is outstanding and not acked this cycle; otherwise IDLE.
  - A fetch at new_pc may be issued the cycle after the flush.
- Ack in DISCARD or IDLE never writes the queue.
- Latency: the first byte is available (ipq_len>0) one cycle after fetch_ack.
- ce low: fetch_ack must not be asserted by the bus; outputs hold.
- Reset mid-request: fetch_req drops immediately. The bus must abandon the cycle.

Optional Feature:
- Macro: NEC_PREFETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetches[31:0] (incremented per accepted ack, including discarded ones), perf_flushes[31:0] (per set_pc) and perf_starve[31:0] (cycles with ipq_len==0 and state!=IDLE).
  - All counters reset to 0 and wrap.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Add prefetch_state_e {PF_IDLE, PF_REQ, PF_DISCARD} to the shared types package.
- Add the constant IPQ_DEPTH=8 there; nec_decode shares it.
- No sub-module: a single always_ff plus combinational address and free-space logic.

Test Plan:
- Reset, ps=0x1000, new_pc=0x0100 via set_pc -> fetch_addr=0x10100; ack 0x3412 -> ipq[0]=0x12, ipq[1]=0x34, ipq_len=2.
- set_pc new_pc=0x0103 -> fetch_addr=0x10102; ack 0xAABB -> ipq[3]=0xAA, ipq_len=1, next fetch_addr=0x10104.
- Continuous acks with no consume -> ipq_len reaches 8, then fetch_req stays low; consume_len=2 -> a request is issued the following cycle.
- set_pc while in REQ, ack 2 cycles later with 0xFFFF -> ipq_len stays 0, no queue write, then a new request at the new address.
- Same-cycle ack (+2) and consume_len=3 with ipq_len=4 -> ipq_len=3, head_pc advanced by 3.
- ps=0xFFFF, pc=0x0020 -> fetch_addr=0x00010 (20-bit wrap); pc=0xFFFE ack -> head wraps correctly to 0x0000 after consume_len=2.
